// File: rtl/router_read_arbiter_if.sv
// Read-side bus between the router output FIFOs, the arbiter and the shared output sink.
// master = arbiter side, slave = router/sink side.
interface router_read_arbiter_if #(
  parameter int NCH = 3,
  parameter int DW  = 8
);
  logic [NCH-1:0]    vld_in;
  logic [NCH*DW-1:0] data_in;
  logic [NCH-1:0]    read_enb;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_ch;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  vld_in, data_in, out_ready,
    output read_enb, out_data, out_ch, out_valid
  );

  modport slave (
    output vld_in, data_in, out_ready,
    input  read_enb, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/router_read_arbiter.sv
// Round-robin burst read scheduler for the 3-channel router output FIFOs.
// Optional per-channel byte counters are built when ARB_STATS_EN is defined.
module router_read_arbiter #(
  parameter int NCH       = 3,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  arb_en,
  router_read_arbiter_if.master bus,
  output logic [1:0]            grant_ch,
  output logic                  busy,
  input  logic [1:0]            stat_sel,
  output logic [7:0]            stat_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      last_q, last_d;
  logic [3:0]      burst_q, burst_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [1:0]      out_ch_q, out_ch_d;
  logic            out_valid_q, out_valid_d;

  logic            free;
  logic            grant_vld;
  logic            pop;
  logic [1:0]      pick;
  logic [1:0]      cand0, cand1, cand2;
  logic [NCH-1:0]  read_enb;
  logic [DW-1:0]   grant_data;

  assign free       = !out_valid_q || bus.out_ready;
  assign grant_vld  = bus.vld_in[grant_q];
  assign grant_data = bus.data_in[grant_q*DW +: DW];
  assign pop        = (state_q == GRANT) && arb_en && grant_vld && free;

  // Search order starts strictly after the last granted channel.
  always_comb begin
    case (last_q)
      2'd0:    {cand0, cand1, cand2} = {2'd1, 2'd2, 2'd0};
      2'd1:    {cand0, cand1, cand2} = {2'd2, 2'd0, 2'd1};
      default: {cand0, cand1, cand2} = {2'd0, 2'd1, 2'd2};
    endcase
    if (bus.vld_in[cand0])      pick = cand0;
    else if (bus.vld_in[cand1]) pick = cand1;
    else                        pick = cand2;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      grant_q     <= 2'd0;
      last_q      <= 2'd2;
      burst_q     <= 4'd0;
      out_data_q  <= '0;
      out_ch_q    <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      burst_q     <= burst_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    burst_d     = burst_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (arb_en && (|bus.vld_in)) begin
          grant_d = pick;
          burst_d = 4'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (pop) begin
          burst_d = burst_q + 4'd1;
          if (burst_q == 4'(MAX_BURST - 1)) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end else if (!grant_vld || !arb_en) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop and a sink accept in the same cycle reload without a bubble.
    if (pop) begin
      out_data_d  = grant_data;
      out_ch_d    = grant_q;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_rd
    assign read_enb[gi] = pop && (grant_q == 2'(gi));
  end

  always_comb begin
    bus.read_enb  = read_enb;
    bus.out_data  = out_data_q;
    bus.out_ch    = out_ch_q;
    bus.out_valid = out_valid_q;
    grant_ch      = grant_q;
    busy          = (state_q == GRANT);
  end

`ifdef ARB_STATS_EN
  logic [7:0] cnt_all [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_stat
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (read_enb[gi] && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) cnt_q <= 8'd0;
      else         cnt_q <= cnt_d;
    end

    assign cnt_all[gi] = cnt_q;
  end

  always_comb begin
    case (stat_sel)
      2'd0:    stat_cnt = cnt_all[0];
      2'd1:    stat_cnt = cnt_all[1];
      2'd2:    stat_cnt = cnt_all[2];
      default: stat_cnt = 8'd0;
    endcase
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = 8'd0;
`endif

endmodule

// File: tb/tb_router_read_arbiter.sv
// Directed bench: per-cycle vector table for a short ch1 burst plus hand-written
// sequences for rotation, backpressure, enable drop, reset and the byte counters.
module tb_router_read_arbiter;

  logic       clk = 1'b0;
  logic       resetn;
  logic       arb_en;
  logic [1:0] grant_ch;
  logic       busy;
  logic [1:0] stat_sel;
  logic [7:0] stat_cnt;

  always #5 clk = ~clk;

  router_read_arbiter_if #(.NCH(3), .DW(8)) bus ();

  router_read_arbiter #(.NCH(3), .DW(8), .MAX_BURST(4)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .arb_en   (arb_en),
    .bus      (bus.master),
    .grant_ch (grant_ch),
    .busy     (busy),
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         pops  = 0;
  logic [7:0] fq [3][$];
  logic [9:0] got_q [$];
  logic [9:0] exp_q [$];
  logic [2:0] re;

  typedef struct {
    logic       arb_en;
    logic       out_ready;
    logic [2:0] exp_re;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [1:0] exp_ch;
    logic       exp_busy;
  } vec_t;

  vec_t tv [6];

  function automatic void check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  task automatic drive_fifo();
    for (int ch = 0; ch < 3; ch++) begin
      bus.vld_in[ch]          = (fq[ch].size() > 0);
      bus.data_in[ch*8 +: 8]  = (fq[ch].size() > 0) ? fq[ch][0] : 8'h00;
    end
  endtask

  // One clock: sample pre-edge strobes/handshake, pop the model FIFO, sample post-edge.
  task automatic cyc(output logic [2:0] re_o);
    drive_fifo();
    #1;
    re_o = bus.read_enb;
    if (re_o != 3'b000) check("read_enb_granted", re_o, 3'b001 << grant_ch);
    if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_ch, bus.out_data});
    @(posedge clk);
    for (int ch = 0; ch < 3; ch++) begin
      if (re_o[ch]) begin
        if (fq[ch].size() > 0) void'(fq[ch].pop_front());
        pops++;
      end
    end
    #1;
    drive_fifo();
    $display("t=%0t re=%b ov=%b od=%h oc=%0d busy=%b gr=%0d", $time, re_o,
             bus.out_valid, bus.out_data, bus.out_ch, busy, grant_ch);
  endtask

  task automatic do_reset();
    for (int ch = 0; ch < 3; ch++) fq[ch].delete();
    got_q.delete();
    exp_q.delete();
    pops          = 0;
    arb_en        = 1'b1;
    bus.out_ready = 1'b1;
    stat_sel      = 2'd0;
    drive_fifo();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic drain(int budget);
    int n = 0;
    logic [2:0] r;
    while (((fq[0].size() + fq[1].size() + fq[2].size()) > 0 || busy || bus.out_valid)
           && n < budget) begin
      cyc(r);
      n++;
    end
    check("drain_done", int'(busy || bus.out_valid), 0);
  endtask

  task automatic compare_stream(string name);
    check($sformatf("%s_len", name), got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", name, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every channel requesting.
    arb_en        = 1'b1;
    bus.out_ready = 1'b1;
    stat_sel      = 2'd0;
    resetn        = 1'b0;
    for (int ch = 0; ch < 3; ch++) fq[ch].push_back(8'h55);
    drive_fifo();
    repeat (3) @(posedge clk);
    #1;
    check("rst_read_enb", bus.read_enb, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_ch", bus.out_ch, 0);
    check("rst_grant_ch", grant_ch, 0);
    check("rst_stat_cnt", stat_cnt, 0);

    // Ch1 holds A1..A3: per-cycle table.
    tv[0] = '{1'b1, 1'b1, 3'b000, 1'b0, 8'h00, 2'd0, 1'b1};
    tv[1] = '{1'b1, 1'b1, 3'b010, 1'b1, 8'hA1, 2'd1, 1'b1};
    tv[2] = '{1'b1, 1'b1, 3'b010, 1'b1, 8'hA2, 2'd1, 1'b1};
    tv[3] = '{1'b1, 1'b1, 3'b010, 1'b1, 8'hA3, 2'd1, 1'b1};
    tv[4] = '{1'b1, 1'b1, 3'b000, 1'b0, 8'h00, 2'd0, 1'b0};
    tv[5] = '{1'b1, 1'b1, 3'b000, 1'b0, 8'h00, 2'd0, 1'b0};
    do_reset();
    fq[1] = '{8'hA1, 8'hA2, 8'hA3};
    for (int v = 0; v < 6; v++) begin
      arb_en        = tv[v].arb_en;
      bus.out_ready = tv[v].out_ready;
      cyc(re);
      check($sformatf("t2_re[%0d]", v), re, tv[v].exp_re);
      check($sformatf("t2_valid[%0d]", v), bus.out_valid, tv[v].exp_valid);
      if (tv[v].exp_valid) begin
        check($sformatf("t2_data[%0d]", v), bus.out_data, tv[v].exp_data);
        check($sformatf("t2_ch[%0d]", v), bus.out_ch, tv[v].exp_ch);
      end
      check($sformatf("t2_busy[%0d]", v), busy, tv[v].exp_busy);
    end

    // All channels hold 6 bytes: bursts of 4 then 2 in round-robin order.
    do_reset();
    for (int ch = 0; ch < 3; ch++)
      for (int i = 0; i < 6; i++) fq[ch].push_back(8'(ch * 16 + i));
    for (int r = 0; r < 2; r++)
      for (int ch = 0; ch < 3; ch++)
        for (int i = (r == 0 ? 0 : 4); i < (r == 0 ? 4 : 6); i++)
          exp_q.push_back({2'(ch), 8'(ch * 16 + i)});
    drain(200);
    compare_stream("t3_rr");

    // Backpressure during a ch2 burst.
    do_reset();
    fq[2] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    for (int n = 0; n < 10 && !bus.out_valid; n++) cyc(re);
    check("t4_first_valid", bus.out_valid, 1);
    bus.out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      cyc(re);
      check($sformatf("t4_stall_re[%0d]", n), re, 0);
      check($sformatf("t4_stall_data[%0d]", n), bus.out_data, 8'hC0);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back({2'd2, 8'hC0 + 8'(i)});
    drain(50);
    compare_stream("t4_bp");

    // arb_en drop after the 2nd pop, then re-enable: next channel in RR order.
    do_reset();
    fq[0] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    fq[1] = '{8'hD0, 8'hD1};
    for (int n = 0; n < 10 && pops < 2; n++) cyc(re);
    check("t5_two_pops", pops, 2);
    arb_en = 1'b0;
    for (int n = 0; n < 4; n++) begin
      cyc(re);
      check($sformatf("t5_off_re[%0d]", n), re, 0);
    end
    check("t5_drained_valid", bus.out_valid, 0);
    check("t5_drained_cnt", got_q.size(), 2);
    arb_en = 1'b1;
    for (int n = 0; n < 5 && !busy; n++) cyc(re);
    check("t5_regrant_ch", grant_ch, 1);
    exp_q = '{{2'd0, 8'hB0}, {2'd0, 8'hB1}, {2'd1, 8'hD0}, {2'd1, 8'hD1},
              {2'd0, 8'hB2}, {2'd0, 8'hB3}};
    drain(60);
    compare_stream("t5_en");

    // Reset mid-burst clears state asynchronously.
    do_reset();
    fq[1] = '{8'hE0, 8'hE1, 8'hE2, 8'hE3};
    cyc(re);
    cyc(re);
    check("t7_pre_valid", bus.out_valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("t7_rst_valid", bus.out_valid, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_data", bus.out_data, 0);
    check("t7_rst_re", bus.read_enb, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Byte counters: 300 pops from ch0.
    do_reset();
    for (int i = 0; i < 300; i++) fq[0].push_back(8'(i));
    drain(600);
    check("t6_pop_count", got_q.size(), 300);
    stat_sel = 2'd0;
    #1;
`ifdef ARB_STATS_EN
    check("t6_stat_ch0", stat_cnt, 255);
`else
    check("t6_stat_ch0", stat_cnt, 0);
`endif
    stat_sel = 2'd1;
    #1;
    check("t6_stat_ch1", stat_cnt, 0);
    stat_sel = 2'd3;
    #1;
    check("t6_stat_sel3", stat_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
